ysyx_25030085_wb_arbiter: RTL and testbench
===========================================

YSYX_25030085_WB_ARBITER -- requirements
Module: ysyx_25030085_wb_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, register data width.
REQ-002 SHALL have port: clk  in  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: exu_valid/lsu_valid/csr_valid  in  1 each  requester holds a write-back.
REQ-005 SHALL have ports: exu_rd/lsu_rd/csr_rd  in  5 each  destination register index.
REQ-006 SHALL have ports: exu_data/lsu_data/csr_data  in  XLEN each  write-back value.
REQ-007 SHALL have ports: exu_ready/lsu_ready/csr_ready  out  1 each  grant; transfer when valid&ready.
REQ-008 SHALL have ports: rf_we  out  1, rf_waddr  out  5, rf_wdata  out  XLEN  register-file write port.
REQ-009 SHALL have ports: iss_valid  in  1, iss_rd  in  5, iss_ready  out  1  destination reservation at issue.
REQ-010 SHALL have ports: q_rs1, q_rs2  in  5; rs1_busy, rs2_busy  out  1  pending-write query.

Function
REQ-011 SHALL grant at most one requester per cycle; ready is combinational from valids and arbitration state.
REQ-012 SHALL assert ready only to the selected requester and only while its valid is high.
REQ-013 SHALL, when macro enabled, arbitrate round-robin: priority starts after last granted requester, order EXU->LSU->CSR->EXU.
REQ-014 SHALL update the round-robin pointer only on a completed transfer; no transfer leaves it unchanged.
REQ-015 SHALL register the accepted transfer: rf_we/rf_waddr/rf_wdata valid exactly one cycle after handshake.
REQ-016 SHALL sustain one write per cycle back-to-back with no bubbles while any valid is high.
REQ-017 SHALL accept transfers with rd=0 (ready asserted) but drive rf_we=0 for them; x0 never written.
REQ-018 SHALL keep a 32-bit busy scoreboard; bit 0 constantly 0.
REQ-019 SHALL set busy[iss_rd] on iss_valid&iss_ready with iss_rd!=0.
REQ-020 SHALL drive iss_ready = ~busy[iss_rd] (no two outstanding writes to one rd; WAW stalls issue).
REQ-021 SHALL clear busy[rf_waddr] on each edge where rf_we=1.
REQ-022 SHALL, on same-edge set and clear of the same index, leave the bit set.
REQ-023 SHALL drive rs1_busy=busy[q_rs1], rs2_busy=busy[q_rs2] combinationally, no bypass from rf_we.
REQ-024 SHALL NOT require requesters to hold data after handshake; data captured at handshake edge.

Reset
REQ-025 SHALL, on rst, clear rf_we, rf_waddr, rf_wdata to 0 and all busy bits to 0.
REQ-026 SHALL, on rst, set round-robin pointer to CSR so first priority is EXU.
REQ-027 SHALL, during rst cycle, drive all *_ready=0 and iss_ready=0; a transfer pending when rst asserts is discarded.

Configuration
REQ-028 SHALL use macro WB_ARB_RR_EN: defined -> round-robin per REQ-013/014.
REQ-029 SHALL, without WB_ARB_RR_EN, use fixed priority LSU > EXU > CSR; pointer logic absent; all else identical.

Verification
REQ-030 Reset then idle -> rf_we=0, all busy=0, iss_ready=1 for iss_rd=5.
REQ-031 RR: exu/lsu/csr all valid, rd=1/2/3, data 0x11/0x22/0x33 held 3 cycles -> rf writes x1=0x11, x2=0x22, x3=0x33 on consecutive cycles, each one cycle after its grant.
REQ-032 Issue iss_rd=7; next cycle iss_rd=7 again -> iss_ready=0; lsu writes rd=7 data 0xDEADBEEF -> rf_we edge clears busy[7], q_rs1=7 shows rs1_busy=1 until that edge, then 0.
REQ-033 exu_valid rd=0 data 0xFFFFFFFF -> exu_ready=1, rf_we stays 0, busy unchanged.
REQ-034 Same cycle iss rd=4 and rf_we with rf_waddr=4 -> busy[4]=1 afterward.
REQ-035 Fixed-priority build, all three valid for 2 cycles -> LSU granted both cycles; rst mid-stream -> next cycle rf_we=0, busy all 0.

Source files
------------

// File: rtl/ysyx_25030085_wb_arbiter.sv
// ysyx_25030085_wb_arbiter
//
// Write-back arbiter for three requesters (EXU, LSU, CSR) sharing one
// register-file write port, plus a per-register busy scoreboard that tracks
// destinations reserved at issue until their write-back retires.
//
// Configuration macro:
//   WB_ARB_RR_EN  defined   -> round-robin arbitration, order EXU->LSU->CSR->EXU,
//                              priority starting after the last granted requester.
//                 undefined -> fixed priority LSU > EXU > CSR.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   exu_/lsu_/csr_valid,_rd,_data    write-back requests
//   exu_/lsu_/csr_ready              grant (transfer on valid & ready)
//   rf_we, rf_waddr, rf_wdata        registered register-file write port
//   iss_valid, iss_rd, iss_ready     destination reservation at issue
//   q_rs1, q_rs2, rs1_busy, rs2_busy pending-write query (no bypass)

module ysyx_25030085_wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            exu_valid,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    output logic            exu_ready,

    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    input  logic            csr_valid,
    input  logic [4:0]      csr_rd,
    input  logic [XLEN-1:0] csr_data,
    output logic            csr_ready,

    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,

    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,

    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    // Requester encoding for the selected index and the round-robin pointer.
    localparam logic [1:0] SEL_EXU = 2'd0;
    localparam logic [1:0] SEL_LSU = 2'd1;
    localparam logic [1:0] SEL_CSR = 2'd2;

    logic [2:0]      w_valid;  // {csr, lsu, exu}
    logic [2:0]      w_gnt;    // one-hot, same bit order as w_valid
    logic [1:0]      w_sel;
    logic            w_xfer;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;

    assign w_valid = {csr_valid, lsu_valid, exu_valid};

`ifdef WB_ARB_RR_EN
    logic [1:0] r_last;

    // Priority starts at the requester after the last one granted.
    always_comb begin
        w_gnt = 3'b000;
        unique case (r_last)
            SEL_EXU: begin
                if      (w_valid[1]) w_gnt = 3'b010;
                else if (w_valid[2]) w_gnt = 3'b100;
                else if (w_valid[0]) w_gnt = 3'b001;
            end
            SEL_LSU: begin
                if      (w_valid[2]) w_gnt = 3'b100;
                else if (w_valid[0]) w_gnt = 3'b001;
                else if (w_valid[1]) w_gnt = 3'b010;
            end
            default: begin
                if      (w_valid[0]) w_gnt = 3'b001;
                else if (w_valid[1]) w_gnt = 3'b010;
                else if (w_valid[2]) w_gnt = 3'b100;
            end
        endcase
    end

    // Pointer moves only on a completed transfer; reset points at CSR so EXU leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= SEL_CSR;
        end else if (w_xfer) begin
            r_last <= w_sel;
        end
    end
`else
    always_comb begin
        w_gnt = 3'b000;
        if      (w_valid[1]) w_gnt = 3'b010;
        else if (w_valid[0]) w_gnt = 3'b001;
        else if (w_valid[2]) w_gnt = 3'b100;
    end
`endif

    // Grants are suppressed during reset so a pending request is discarded.
    assign exu_ready = w_gnt[0] & ~rst;
    assign lsu_ready = w_gnt[1] & ~rst;
    assign csr_ready = w_gnt[2] & ~rst;
    assign w_xfer    = exu_ready | lsu_ready | csr_ready;

    always_comb begin
        w_sel      = SEL_EXU;
        w_sel_rd   = exu_rd;
        w_sel_data = exu_data;
        unique case (1'b1)
            w_gnt[1]: begin
                w_sel      = SEL_LSU;
                w_sel_rd   = lsu_rd;
                w_sel_data = lsu_data;
            end
            w_gnt[2]: begin
                w_sel      = SEL_CSR;
                w_sel_rd   = csr_rd;
                w_sel_data = csr_data;
            end
            default: begin
                w_sel      = SEL_EXU;
                w_sel_rd   = exu_rd;
                w_sel_data = exu_data;
            end
        endcase
    end

    // Data captured at the handshake edge; rd=0 is accepted but never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (w_xfer) begin
            rf_we    <= (w_sel_rd != 5'd0);
            rf_waddr <= w_sel_rd;
            rf_wdata <= w_sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Busy scoreboard.
    logic [31:0] r_busy;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_next;
    logic        w_iss_fire;

    assign iss_ready  = ~rst & ~r_busy[iss_rd];
    assign w_iss_fire = iss_valid & iss_ready & (iss_rd != 5'd0);
    assign w_set_mask = w_iss_fire ? (32'd1 << iss_rd) : 32'd0;
    assign w_clr_mask = rf_we ? (32'd1 << rf_waddr) : 32'd0;

    // Set wins over clear when both hit the same index on one edge.
    always_comb begin
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign rs1_busy = r_busy[q_rs1];
    assign rs2_busy = r_busy[q_rs2];

endmodule

// File: tb/tb_ysyx_25030085_wb_arbiter.sv
// Testbench for ysyx_25030085_wb_arbiter: directed scenarios followed by
// random traffic, all checked against a behavioural model of arbitration,
// the registered write port and the busy scoreboard.
// Build with +define+WB_ARB_RR_EN to check the round-robin variant.

module tb_ysyx_25030085_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, csr_valid;
    logic [4:0]  exu_rd, lsu_rd, csr_rd;
    logic [31:0] exu_data, lsu_data, csr_data;
    logic        exu_ready, lsu_ready, csr_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  q_rs1, q_rs2;
    logic        rs1_busy, rs2_busy;

    ysyx_25030085_wb_arbiter #(.XLEN(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .exu_ready (exu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .csr_valid (csr_valid),
        .csr_rd    (csr_rd),
        .csr_data  (csr_data),
        .csr_ready (csr_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: requester 0=EXU, 1=LSU, 2=CSR.
    int          m_last = 2;
    bit          m_busy [32];
    bit          m_we = 1'b0;
    bit [4:0]    m_waddr = '0;
    bit [31:0]   m_wdata = '0;
    bit          m_addr_chk = 1'b1;

    function automatic int exp_grant(input bit [2:0] v);
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
`else
        if (v[1]) return 1;
        if (v[0]) return 0;
        if (v[2]) return 2;
        return -1;
`endif
    endfunction

    task automatic idle_inputs();
        exu_valid = 0; lsu_valid = 0; csr_valid = 0;
        exu_rd = 0; lsu_rd = 0; csr_rd = 0;
        exu_data = 0; lsu_data = 0; csr_data = 0;
        iss_valid = 0; iss_rd = 0; q_rs1 = 0; q_rs2 = 0;
    endtask

    // Check outputs at the falling edge, advance the model, then return just
    // after the next rising edge so the caller can drive new inputs.
    task automatic step();
        bit [2:0]  v;
        bit [4:0]  rds [3];
        bit [31:0] ds  [3];
        int        g;
        bit [2:0]  exp_rdy;
        bit        nb [32];
        @(negedge clk);
        v   = {csr_valid, lsu_valid, exu_valid};
        rds = '{exu_rd, lsu_rd, csr_rd};
        ds  = '{exu_data, lsu_data, csr_data};
        g   = exp_grant(v);
        exp_rdy = (rst || g < 0) ? 3'b000 : 3'(1 << g);
        check("ready", {29'd0, csr_ready, lsu_ready, exu_ready}, {29'd0, exp_rdy});
        check("iss_ready", {31'd0, iss_ready}, {31'd0, !rst && !m_busy[iss_rd]});
        check("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_busy[q_rs1]});
        check("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_busy[q_rs2]});
        check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        if (m_addr_chk) begin
            check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            check("rf_wdata", rf_wdata, m_wdata);
        end
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0; m_last = 2; m_addr_chk = 1;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_waddr] = 0;
            if (iss_valid && iss_rd != 0 && !m_busy[iss_rd]) nb[iss_rd] = 1;
            m_busy = nb;
            if (g >= 0) begin
                m_we = (rds[g] != 0);
                m_waddr = rds[g];
                m_wdata = ds[g];
                m_last = g;
                m_addr_chk = m_we;
            end else begin
                m_we = 0;
                m_addr_chk = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        foreach (m_busy[i]) m_busy[i] = 0;
        rst = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        step();                      // reset held: outputs cleared
        rst = 0;
        iss_rd = 5;
        step();                      // idle after reset, iss_ready for x5
        step();

        // All three requesters valid for three cycles.
        exu_valid = 1; exu_rd = 1; exu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
        csr_valid = 1; csr_rd = 3; csr_data = 32'h33;
        repeat (3) step();
        idle_inputs();
        step();
        step();

        // Reserve x7, attempt a second reservation, then retire it via LSU.
        iss_valid = 1; iss_rd = 7; q_rs1 = 7;
        step();
        step();                      // WAW: iss_ready low
        iss_valid = 0;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hDEADBEEF;
        step();
        lsu_valid = 0;
        step();                      // rf_we for x7, busy still visible
        step();                      // cleared

        // rd=0 accepted but never written.
        exu_valid = 1; exu_rd = 0; exu_data = 32'hFFFFFFFF; q_rs1 = 0;
        step();
        exu_valid = 0;
        step();

        // Same-edge set and clear of x4 leaves it set.
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444; q_rs2 = 4;
        step();
        lsu_valid = 0; iss_valid = 1; iss_rd = 4;
        step();
        iss_valid = 0;
        step();

        // Reset mid-stream with traffic pending.
        exu_valid = 1; lsu_valid = 1; csr_valid = 1;
        exu_rd = 9; lsu_rd = 10; csr_rd = 11;
        iss_valid = 1; iss_rd = 12;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        idle_inputs();
        q_rs1 = 12;
        step();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            exu_valid = $urandom_range(0, 1);
            lsu_valid = $urandom_range(0, 2) == 0;
            csr_valid = $urandom_range(0, 3) == 0;
            exu_rd    = 5'($urandom_range(0, 7));
            lsu_rd    = 5'($urandom_range(0, 7));
            csr_rd    = 5'($urandom_range(0, 7));
            exu_data  = $urandom;
            lsu_data  = $urandom;
            csr_data  = $urandom;
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 5'($urandom_range(0, 7));
            q_rs1     = 5'($urandom_range(0, 7));
            q_rs2     = 5'($urandom_range(0, 31));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
